mp3_dualport_mem_responder: RTL

Responder end of the two-port CPU memory interface. Port A carries instruction fetch and port B carries data load/store. The block serves both ports from one single-ported 16-bit word array, with a configurable access latency and alternating arbitration between the ports. It sits outside the CPU as the memory/cache stand-in, for simulation benches and early integration.

---
 rtl/mp3_dualport_mem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mp3_dualport_mem_responder.sv
// Two-port (fetch A / data B) memory responder over one single-ported 16-bit
// word array, with fixed access latency and alternating arbitration on contention.
module mp3_dualport_mem_responder #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic        write_a,
  input  logic [1:0]  wmask_a,
  input  logic [15:0] address_a,
  input  logic [15:0] wdata_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b
);
  localparam int IW    = ADDR_BITS - 1;
  localparam int WORDS = 2 ** IW;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          last_b, last_b_nx;
  logic          own_b, op_wr;
  logic [IW-1:0] idx;
  logic [1:0]    mask;
  logic [15:0]   wdata;
  logic [15:0]   mem [WORDS];

  logic          req_a, req_b, grant, grant_b, grant_wr, rd_fire, rd_b;
  logic [IW-1:0] grant_idx, rd_idx;
  logic [15:0]   rd_word;
  logic          unused_addr;

  assign req_a = read_a | write_a;
  assign req_b = read_b | write_b;
  // Under contention B wins unless B was the last contended grant.
  assign grant_b   = req_b && (!req_a || !last_b);
  assign grant_wr  = grant_b ? write_b : write_a;
  assign grant_idx = grant_b ? address_b[ADDR_BITS-1:1] : address_a[ADDR_BITS-1:1];
  assign unused_addr = ^{address_a, address_b};

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    last_b_nx = last_b;
    grant     = 1'b0;
    case (state)
      IDLE: if (req_a || req_b) begin
        grant = 1'b1;
        if (req_a && req_b) last_b_nx = grant_b;
        if (LATENCY == 1) state_nx = DONE;
        else begin
          state_nx = ACCESS;
          cnt_nx   = 4'(LATENCY - 1);
        end
      end
      ACCESS: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read data is captured on the edge entering DONE; with LATENCY=1 that edge
  // is the grant edge itself, so the live request supplies owner and index.
  assign rd_b    = (state == IDLE) ? grant_b : own_b;
  assign rd_idx  = (state == IDLE) ? grant_idx : idx;
  assign rd_word = mem[rd_idx];
  assign rd_fire = (state != DONE) && (state_nx == DONE) &&
                   !((state == IDLE) ? grant_wr : op_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last_b  <= 1'b0;
      own_b   <= 1'b0;
      op_wr   <= 1'b0;
      idx     <= '0;
      mask    <= '0;
      wdata   <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      last_b <= last_b_nx;
      if (grant) begin
        own_b <= grant_b;
        op_wr <= grant_wr;
        idx   <= grant_idx;
        mask  <= grant_b ? wmask_b : wmask_a;
        wdata <= grant_b ? wdata_b : wdata_a;
      end
      if (rd_fire) begin
        if (rd_b) rdata_b <= rd_word;
        else      rdata_a <= rd_word;
      end
    end
  end

  // Array is deliberately not reset; a reset during DONE forces IDLE first,
  // so an abandoned write never reaches this edge.
  always_ff @(posedge clk) begin
    if (state == DONE && op_wr) begin
      if (mask[0]) mem[idx][7:0]  <= wdata[7:0];
      if (mask[1]) mem[idx][15:8] <= wdata[15:8];
    end
  end

  assign resp_a = (state == DONE) && !own_b;
  assign resp_b = (state == DONE) && own_b;
endmodule
